// File: rtl/branch_target_unit.sv
// Branch/jump/indirect target generation behind a stall/flush-aware stage,
// feeding a direct-mapped branch target buffer that IF reads combinationally.
module branch_target_unit #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned SHIFT     = 2,
    parameter int unsigned BTB_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              stall,
    input  logic              flush,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] pcp4,
    input  logic [ADDR_W-1:0] imm,
    input  logic [ADDR_W-1:0] rs_val,
    input  logic              taken,
    input  logic              btb_clear,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_target,
    output logic              out_taken,
    output logic              out_misaligned,
    output logic              out_illegal,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              btb_hit,
    output logic [ADDR_W-1:0] btb_target
);

    localparam int unsigned IDX_W  = $clog2(BTB_DEPTH);
    localparam int unsigned WORD_W = ADDR_W - SHIFT;
    localparam int unsigned TAG_W  = WORD_W - IDX_W;
    localparam logic [ADDR_W-1:0] GRAN       = ADDR_W'(1) << SHIFT;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = GRAN - ADDR_W'(1);

    localparam logic [1:0] MODE_BRANCH = 2'b00;
    localparam logic [1:0] MODE_JUMP   = 2'b01;
    localparam logic [1:0] MODE_REG    = 2'b10;

    logic [ADDR_W-1:0] imm_sh_c;
    logic [ADDR_W-1:0] target_c;
    logic              taken_c;
    logic              misaligned_c;
    logic              illegal_c;
    logic [ADDR_W-1:0] src_pc;

    assign imm_sh_c = imm << SHIFT;

    // Target, effective-taken and fault flags for the instruction presented by ID
    always_comb begin
        target_c     = pcp4;
        taken_c      = 1'b0;
        misaligned_c = 1'b0;
        illegal_c    = 1'b0;
        case (mode)
            MODE_BRANCH: begin
                target_c = pcp4 + imm_sh_c;
                taken_c  = taken;
            end
            MODE_JUMP: begin
                target_c = {pcp4[ADDR_W-1 -: 4], imm_sh_c[ADDR_W-5:0]};
                taken_c  = 1'b1;
            end
            MODE_REG: begin
                target_c     = rs_val;
                taken_c      = 1'b1;
                misaligned_c = |(rs_val & ALIGN_MASK);
            end
            default: illegal_c = 1'b1;
        endcase
    end

    // Result stage: flush beats stall beats load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            out_target     <= '0;
            out_taken      <= 1'b0;
            out_misaligned <= 1'b0;
            out_illegal    <= 1'b0;
            src_pc         <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (!stall) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_target     <= target_c;
                out_taken      <= taken_c;
                out_misaligned <= misaligned_c;
                out_illegal    <= illegal_c;
                src_pc         <= pcp4 - GRAN;
            end
        end
    end

    logic              write_en_c;
    logic [WORD_W-1:0] src_word_c;
    logic [IDX_W-1:0]  wr_idx_c;
    logic [TAG_W-1:0]  wr_tag_c;

    assign write_en_c = out_valid & out_taken & ~out_misaligned & ~out_illegal & ~flush;
    assign src_word_c = WORD_W'(src_pc >> SHIFT);
    assign wr_idx_c   = src_word_c[IDX_W-1:0];
    assign wr_tag_c   = src_word_c[WORD_W-1:IDX_W];

    logic [BTB_DEPTH-1:0] btb_valid;
    logic [TAG_W-1:0]     btb_tag [BTB_DEPTH];
    logic [ADDR_W-1:0]    btb_tgt [BTB_DEPTH];

    // Valid bits reset and clear; clear takes priority over a same-edge allocate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btb_valid <= '0;
        end else if (btb_clear) begin
            btb_valid <= '0;
        end else if (write_en_c) begin
            btb_valid[wr_idx_c] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (write_en_c) begin
            btb_tag[wr_idx_c] <= wr_tag_c;
            btb_tgt[wr_idx_c] <= out_target;
        end
    end

    logic [WORD_W-1:0] look_word_c;
    logic [IDX_W-1:0]  look_idx_c;
    logic [TAG_W-1:0]  look_tag_c;

    assign look_word_c = WORD_W'(lookup_pc >> SHIFT);
    assign look_idx_c  = look_word_c[IDX_W-1:0];
    assign look_tag_c  = look_word_c[WORD_W-1:IDX_W];

    // Prediction read for IF; no bypass of a write landing on this edge
    assign btb_hit    = btb_valid[look_idx_c] && (btb_tag[look_idx_c] == look_tag_c);
    assign btb_target = btb_hit ? btb_tgt[look_idx_c] : '0;

endmodule

// File: tb/tb_branch_target_unit.sv
// Scoreboard bench for branch_target_unit (ADDR_W=32, SHIFT=2, BTB_DEPTH=16).
module tb_branch_target_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [31:0] pcp4 = '0;
    logic [31:0] imm = '0;
    logic [31:0] rs_val = '0;
    logic        taken = 1'b0;
    logic        btb_clear = 1'b0;
    logic        out_valid;
    logic [31:0] out_target;
    logic        out_taken;
    logic        out_misaligned;
    logic        out_illegal;
    logic [31:0] lookup_pc = '0;
    logic        btb_hit;
    logic [31:0] btb_target;

    branch_target_unit #(.ADDR_W(32), .SHIFT(2), .BTB_DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
        .mode(mode), .pcp4(pcp4), .imm(imm), .rs_val(rs_val), .taken(taken),
        .btb_clear(btb_clear), .out_valid(out_valid), .out_target(out_target),
        .out_taken(out_taken), .out_misaligned(out_misaligned), .out_illegal(out_illegal),
        .lookup_pc(lookup_pc), .btb_hit(btb_hit), .btb_target(btb_target)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] tgt;
        logic        tk;
        logic        mis;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic loaded = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // An edge that loads the stage produces exactly one fresh result
    always @(posedge clk) loaded <= rst_n && in_valid && !stall && !flush;

    always @(negedge clk) begin
        if (loaded) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_underflow: got result %h expected none", out_target);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("mon_valid", 32'(out_valid), 32'd1);
                chk("mon_target", out_target, e.tgt);
                chk("mon_taken", 32'(out_taken), 32'(e.tk));
                chk("mon_misaligned", 32'(out_misaligned), 32'(e.mis));
                chk("mon_illegal", 32'(out_illegal), 32'(e.ill));
            end
        end
    end

    task automatic issue(input logic [1:0] m, input logic [31:0] p, input logic [31:0] i,
                         input logic [31:0] r, input logic t, input logic [31:0] etgt,
                         input logic etk, input logic emis, input logic eill);
        mode = m; pcp4 = p; imm = i; rs_val = r; taken = t; in_valid = 1'b1;
        sb.push_back('{tgt: etgt, tk: etk, mis: emis, ill: eill});
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic look(input string name, input logic [31:0] a, input logic eh,
                        input logic [31:0] et);
        lookup_pc = a;
        #1;
        chk({name, "_hit"}, 32'(btb_hit), 32'(eh));
        chk({name, "_tgt"}, btb_target, et);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #3;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_target", out_target, 32'd0);
        chk("rst_taken", 32'(out_taken), 32'd0);
        chk("rst_flags", {30'd0, out_misaligned, out_illegal}, 32'd0);
        look("rst_look", 32'h0, 1'b0, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);

        // Backward branch, then predicted on the following cycle
        issue(2'b00, 32'h0000_0104, 32'hFFFF_FFFE, '0, 1'b1, 32'h0000_00FC, 1, 0, 0);
        idle(1);
        look("br_look", 32'h100, 1'b1, 32'hFC);

        issue(2'b01, 32'h4000_0010, 32'h0000_0040, '0, 1'b0, 32'h4000_0100, 1, 0, 0);
        idle(1);
        look("jmp_look", 32'h4000_000C, 1'b1, 32'h4000_0100);

        // Misaligned indirect must not overwrite index 3
        issue(2'b10, 32'h0000_1010, '0, 32'h0000_1002, 1'b0, 32'h0000_1002, 1, 1, 0);
        idle(1);
        look("mis_look", 32'h100C, 1'b0, 32'h0);
        look("mis_keep", 32'h4000_000C, 1'b1, 32'h4000_0100);

        issue(2'b00, 32'h0000_0204, 32'h4, '0, 1'b0, 32'h0000_0214, 0, 0, 0);
        idle(1);
        look("nt_look", 32'h200, 1'b0, 32'h0);
        look("nt_keep", 32'h100, 1'b1, 32'hFC);

        issue(2'b11, 32'h0000_0304, 32'h1234, 32'h5, 1'b1, 32'h0000_0304, 0, 0, 1);
        idle(1);
        look("ill_look", 32'h300, 1'b0, 32'h0);
        look("ill_keep", 32'h100, 1'b1, 32'hFC);

        // Alias 0x140 onto index 0; write still pending this cycle
        issue(2'b00, 32'h0000_0144, 32'h8, '0, 1'b1, 32'h0000_0164, 1, 0, 0);
        look("alias_same_new", 32'h140, 1'b0, 32'h0);
        look("alias_same_old", 32'h100, 1'b1, 32'hFC);
        idle(1);
        look("alias_new", 32'h140, 1'b1, 32'h164);
        look("alias_old", 32'h100, 1'b0, 32'h0);

        // Stall holds against changing inputs, then flush kills
        issue(2'b10, 32'h0000_0504, '0, 32'h0000_2000, 1'b0, 32'h0000_2000, 1, 0, 0);
        stall = 1'b1; in_valid = 1'b1; mode = 2'b00; pcp4 = 32'h600; imm = 32'h1; taken = 1'b0;
        for (int k = 0; k < 3; k++) begin
            idle(1);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_target", out_target, 32'h2000);
            chk("stall_taken", 32'(out_taken), 32'd1);
        end
        flush = 1'b1;
        idle(1);
        chk("flush_valid", 32'(out_valid), 32'd0);
        stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
        look("stall_look", 32'h500, 1'b1, 32'h2000);

        // Populate indices 0..3, then clear everything
        issue(2'b10, 32'h1004, '0, 32'h8000, 1'b0, 32'h8000, 1, 0, 0);
        issue(2'b10, 32'h1008, '0, 32'h8004, 1'b0, 32'h8004, 1, 0, 0);
        issue(2'b10, 32'h100C, '0, 32'h8008, 1'b0, 32'h8008, 1, 0, 0);
        issue(2'b10, 32'h1010, '0, 32'h800C, 1'b0, 32'h800C, 1, 0, 0);
        idle(1);
        look("pop_look0", 32'h1000, 1'b1, 32'h8000);
        look("pop_look3", 32'h100C, 1'b1, 32'h800C);
        btb_clear = 1'b1;
        idle(1);
        btb_clear = 1'b0;
        look("clr_look0", 32'h1000, 1'b0, 32'h0);
        look("clr_look1", 32'h1004, 1'b0, 32'h0);
        look("clr_look2", 32'h1008, 1'b0, 32'h0);
        look("clr_look3", 32'h100C, 1'b0, 32'h0);

        // Async reset in the middle of a stalled, writing cycle
        issue(2'b00, 32'h0000_0104, 32'hFFFF_FFFE, '0, 1'b1, 32'h0000_00FC, 1, 0, 0);
        stall = 1'b1;
        idle(1);
        look("pre_rst_look", 32'h100, 1'b1, 32'hFC);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_target", out_target, 32'd0);
        look("arst_look", 32'h100, 1'b0, 32'h0);
        stall = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(2);
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
